// File: rtl/fpu_result_logger_pkg.sv
// Shared constants and FSM encoding for the FPU test-vector ROM, result logger and UART wrappers.
package fpu_result_logger_pkg;

  localparam int W_SP   = 32;
  localparam int W_DP   = 64;
  localparam int LOG_AW = 10;

  typedef enum logic [1:0] {
    LOG = 2'd0,
    RD  = 2'd1,
    TX  = 2'd2,
    FIN = 2'd3
  } state_t;

  function automatic int bytes_per_entry(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/fpu_result_logger_log_ram.sv
// Simple dual-port log storage: one write port, one registered read port (block RAM friendly).
module log_ram #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fpu_result_logger.sv
// Logs FPU results into RAM and, on request, streams the log MSB-first to a UART transmitter.
module fpu_result_logger
  import fpu_result_logger_pkg::*;
#(
  parameter int W  = W_SP,
  parameter int AW = LOG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          result_valid,
  input  logic [W-1:0]  result_data,
  input  logic          dump_start,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          busy,
  output logic          dump_done
);

  localparam int NB  = bytes_per_entry(W);
  localparam int BCW = $clog2(NB);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic            fwd_q, fwd_d;
  logic [W-1:0]    fwd_data_q, fwd_data_d;

  logic            full_w;
  logic            wr_en;
  logic            xfer;
  logic            last_byte;
  logic            last_entry;
  logic [AW:0]     rd_next_cnt;
  logic [W-1:0]    ram_rdata;

  assign full_w      = (count_q == DEPTH);
  assign wr_en       = (state_q == LOG) && result_valid && !full_w;
  assign xfer        = (state_q == TX) && tx_ready;
  assign last_byte   = (byte_cnt_q == '0);
  assign rd_next_cnt = {1'b0, rd_ptr_q} + {{AW{1'b0}}, 1'b1};
  assign last_entry  = (rd_next_cnt == count_q);

  // Read address follows the next-state pointer so the data is ready during RD.
  log_ram #(
    .W  (W),
    .AW (AW)
  ) u_log_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (result_data),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOG;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOG: if (dump_start) state_d = (count_q == '0 && !wr_en) ? FIN : RD;
      RD:  state_d = TX;
      TX:  if (xfer && last_byte) state_d = last_entry ? FIN : RD;
      FIN: state_d = LOG;
      default: state_d = LOG;
    endcase
  end

  always_comb begin
    tx_valid  = (state_q == TX);
    busy      = (state_q == RD) || (state_q == TX);
    dump_done = (state_q == FIN);
    tx_data   = shreg_q[W-1 -: 8];
  end

  assign count = count_q;
  assign full  = full_w;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    fwd_d      = 1'b0;
    fwd_data_d = fwd_data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      count_d  = count_q + {{AW{1'b0}}, 1'b1};
    end
    unique case (state_q)
      LOG: begin
        if (dump_start) begin
          rd_ptr_d = '0;
          // A write landing on address 0 alongside dump_start collides with the read; bypass it.
          fwd_d      = wr_en && (wr_ptr_q == '0);
          fwd_data_d = result_data;
        end
      end
      RD: begin
        shreg_d    = fwd_q ? fwd_data_q : ram_rdata;
        byte_cnt_d = BCW'(NB - 1);
      end
      TX: begin
        if (xfer) begin
          shreg_d    = {shreg_q[W-9:0], 8'h00};
          byte_cnt_d = byte_cnt_q - {{(BCW-1){1'b0}}, 1'b1};
          if (last_byte && !last_entry) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
      end
      FIN: begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule
